// File: rtl/c2c_pkg.sv
// Shared types for the core-to-cache read arbiter.
// No logic, so no latency of its own.
// No flow control of its own; types only.
package c2c_pkg;

  // Arbitration policy: lowest index always wins, or rotating priority.
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Arbiter state: IDLE samples requests, BUSY holds one request until ack.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } c2c_arb_state_e;

  // Width of a master index; never less than one bit.
  function automatic int c2c_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/c2c_r_arbiter_picker.sv
// Rotating-priority picker: first requester at or after ptr, wrapping mod N.
// Combinational, zero cycles.
// No flow control; grant is only meaningful while any_req is high.
module rr_picker
  import c2c_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = c2c_idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_grant,
  output logic          o_any_req
);

  // Pick the requester with the smallest cyclic distance from ptr; distance is
  // computed with an explicit wrap so non-power-of-two N never yields index >= N.
  always_comb begin
    int v_best;
    int v_dist;
    o_grant   = '0;
    o_any_req = 1'b0;
    v_best    = N;
    v_dist    = 0;
    for (int i = 0; i < N; i++) begin
      v_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N - int'(i_ptr));
      if (i_req[i] && (v_dist < v_best)) begin
        v_best    = v_dist;
        o_grant   = PW'(i);
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/c2c_r_arbiter.sv
// N-to-1 arbiter sharing one cache read port among several read requesters.
// Request in IDLE cycle T drives s_re from T+1; m_ack is combinational with s_ack.
// One transaction in flight; requests wait (m_re held) until the port goes IDLE.
module c2c_r_arbiter
  import c2c_pkg::*;
#(
  parameter  int        XLEN        = 32,
  parameter  int        NUM_MASTERS = 2,
  parameter  arb_mode_e ARB_MODE    = ARB_RR,
  localparam int        SW          = XLEN / 8,
  localparam int        PW          = c2c_idx_w(NUM_MASTERS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_MASTERS-1:0]                m_re,
  input  logic [NUM_MASTERS-1:0][SW-1:0]        m_sel,
  input  logic [NUM_MASTERS-1:0][XLEN-1:0]      m_addr,
  output logic [NUM_MASTERS-1:0]                m_ack,
  output logic [NUM_MASTERS-1:0][XLEN-1:0]      m_data,
  output logic                                  s_re,
  output logic [SW-1:0]                         s_sel,
  output logic [XLEN-1:0]                       s_addr,
  input  logic                                  s_ack,
  input  logic [XLEN-1:0]                       s_data
);

  c2c_arb_state_e  r_state;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;
  logic            r_s_re;
  logic [SW-1:0]   r_s_sel;
  logic [XLEN-1:0] r_s_addr;

  logic [PW-1:0]   w_ptr;
  logic [PW-1:0]   w_grant;
  logic            w_any_req;
  logic [PW-1:0]   w_next_ptr;

  // Fixed priority is the rotating picker pinned to start at master 0.
  assign w_ptr      = (ARB_MODE == ARB_RR) ? r_rr_ptr : '0;
  assign w_next_ptr = (r_owner == PW'(NUM_MASTERS - 1)) ? '0 : (r_owner + PW'(1));

  rr_picker #(.N(NUM_MASTERS)) u_picker (
    .i_req     (m_re),
    .i_ptr     (w_ptr),
    .o_grant   (w_grant),
    .o_any_req (w_any_req)
  );

  // Request latch: sample a winner in IDLE, hold it unchanged until the cache acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_s_re   <= 1'b0;
      r_s_sel  <= '0;
      r_s_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_s_addr <= m_addr[w_grant];
            r_s_sel  <= m_sel[w_grant];
            r_owner  <= w_grant;
            r_s_re   <= 1'b1;
            r_state  <= BUSY;
          end else begin
            r_s_re   <= 1'b0;
          end
        end
        BUSY: begin
          if (s_ack) begin
            r_s_re  <= 1'b0;
            r_state <= IDLE;
            if (ARB_MODE == ARB_RR) begin
              r_rr_ptr <= w_next_ptr;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_s_re  <= 1'b0;
        end
      endcase
    end
  end

  assign s_re   = r_s_re;
  assign s_sel  = r_s_sel;
  assign s_addr = r_s_addr;

  // Ack goes only to the owner, and only while a transaction is in flight.
  always_comb begin
    m_ack = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_ack[i] = s_ack && (r_state == BUSY) && (r_owner == PW'(i));
    end
  end

  // Read data is broadcast; each master qualifies it with its own ack.
  always_comb begin
    m_data = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_data[i] = s_data;
    end
  end

endmodule

// File: tb/tb_c2c_r_arbiter.sv
// Self-checking bench: directed scenarios plus randomized stress vs a request-level model.
// Cache latency is programmable per transaction (0..5 cycles).
// Masters hold m_re until acked and drop it the following cycle.
module tb_c2c_r_arbiter;
  import c2c_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [2:0]        m_re;
  logic [2:0][3:0]   m_sel;
  logic [2:0][31:0]  m_addr;
  logic [2:0]        m_ack;
  logic [2:0][31:0]  m_data;
  logic              s_re;
  logic [3:0]        s_sel;
  logic [31:0]       s_addr;
  logic              s_ack;
  logic [31:0]       s_data;

  logic [2:0]        f_m_re;
  logic [2:0][3:0]   f_m_sel;
  logic [2:0][31:0]  f_m_addr;
  logic [2:0]        f_m_ack;
  logic [2:0][31:0]  f_m_data;
  logic              f_s_re;
  logic [3:0]        f_s_sel;
  logic [31:0]       f_s_addr;
  logic              f_s_ack;
  logic [31:0]       f_s_data;

  int checks = 0;
  int errors = 0;
  int mdl_last = 2;   // last master served by the RR instance; ptr = mdl_last+1

  c2c_r_arbiter #(.XLEN(32), .NUM_MASTERS(3), .ARB_MODE(ARB_RR)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m_re(m_re), .m_sel(m_sel), .m_addr(m_addr), .m_ack(m_ack), .m_data(m_data),
    .s_re(s_re), .s_sel(s_sel), .s_addr(s_addr), .s_ack(s_ack), .s_data(s_data)
  );

  c2c_r_arbiter #(.XLEN(32), .NUM_MASTERS(3), .ARB_MODE(ARB_FIXED)) u_dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .m_re(f_m_re), .m_sel(f_m_sel), .m_addr(f_m_addr), .m_ack(f_m_ack), .m_data(f_m_data),
    .s_re(f_s_re), .s_sel(f_s_sel), .s_addr(f_s_addr), .s_ack(f_s_ack), .s_data(f_s_data)
  );

  always #5 clk = ~clk;

  // Round-robin model: first requester after the last one served, cyclically.
  function automatic int rr_pick(input logic [2:0] req, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (req[(last + k) % 3]) return (last + k) % 3;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    m_re = 3'b111; s_ack = 1'b1; s_data = 32'h1234_5678;
    m_addr[0] = 32'h55; m_addr[1] = 32'h66; m_addr[2] = 32'h77;
    m_sel = '1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (s_re !== 1'b0 || s_addr !== 32'h0 || s_sel !== 4'h0)
      begin errors++; $display("FAIL reset_state got s_re=%b s_addr=%h s_sel=%h want 0/0/0", s_re, s_addr, s_sel); end
    checks++;
    if (m_ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b want 000", m_ack); end
    rst_n = 1'b1; s_ack = 1'b0; m_re = 3'b000; mdl_last = 2;
    // master 0 completes with zero latency, moving the pointer to 1
    tick();
    m_re = 3'b001; m_addr[0] = 32'h100;
    tick();
    checks++;
    if (s_re !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL reset_pre_txn got s_re=%b s_addr=%h want 1/100", s_re, s_addr); end
    s_ack = 1'b1; #1;
    checks++;
    if (m_ack !== 3'b001) begin errors++; $display("FAIL reset_pre_ack got %b want 001", m_ack); end
    tick();
    s_ack = 1'b0; m_re = 3'b000; mdl_last = 0;
    // master 2 granted, then reset lands mid-transaction
    m_re = 3'b100; m_addr[2] = 32'h200;
    tick();
    checks++;
    if (s_re !== 1'b1 || s_addr !== 32'h200) begin errors++; $display("FAIL reset_busy got s_re=%b s_addr=%h want 1/200", s_re, s_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_re !== 1'b0) begin errors++; $display("FAIL reset_async got s_re=%b want 0", s_re); end
    m_re = 3'b000;
    tick(); tick();
    rst_n = 1'b1; mdl_last = 2;
    // pointer back at 0: with everyone requesting, master 0 must win
    m_re = 3'b111; m_addr[0] = 32'h300; m_addr[1] = 32'h310; m_addr[2] = 32'h320;
    d = m_addr[rr_pick(3'b111, mdl_last)];
    tick();
    checks++;
    if (s_re !== 1'b1 || s_addr !== d) begin errors++; $display("FAIL reset_ptr got s_addr=%h want %h", s_addr, d); end
    tick();
    s_ack = 1'b1; #1;
    checks++;
    if (m_ack !== 3'b001) begin errors++; $display("FAIL reset_ptr_ack got %b want 001", m_ack); end
    tick();
    s_ack = 1'b0; m_re = 3'b000; mdl_last = 0;
  endtask

  task automatic test_single();
    m_re = 3'b010; m_addr[1] = 32'h1000; m_sel[1] = 4'hF;
    tick();
    checks++;
    if (s_re !== 1'b1 || s_addr !== 32'h1000 || s_sel !== 4'hF)
      begin errors++; $display("FAIL single_req got s_re=%b s_addr=%h s_sel=%h want 1/1000/f", s_re, s_addr, s_sel); end
    #1;
    checks++;
    if (m_ack !== 3'b000) begin errors++; $display("FAIL single_noack got %b want 000", m_ack); end
    tick(); tick();
    s_ack = 1'b1; s_data = 32'hDEADBEEF; #1;
    checks++;
    if (m_ack !== 3'b010 || m_data[1] !== 32'hDEADBEEF)
      begin errors++; $display("FAIL single_ack got m_ack=%b m_data1=%h want 010/deadbeef", m_ack, m_data[1]); end
    tick();
    s_ack = 1'b0; m_re = 3'b000; mdl_last = 1;
    checks++;
    if (s_re !== 1'b0) begin errors++; $display("FAIL single_release got s_re=%b want 0", s_re); end
  endtask

  task automatic test_rr_fair();
    int exp;
    logic [31:0] d;
    #1 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1; mdl_last = 2;
    for (int i = 0; i < 3; i++) m_addr[i] = 32'hA000_0000 + 32'(i * 16);
    m_re = 3'b111;
    for (int g = 0; g < 6; g++) begin
      exp = rr_pick(3'b111, mdl_last);
      tick();
      checks++;
      if (s_re !== 1'b1 || s_addr !== m_addr[exp] || m_ack !== 3'b000)
        begin errors++; $display("FAIL rr_grant%0d got s_addr=%h m_ack=%b want %h/000", g, s_addr, m_ack, m_addr[exp]); end
      tick(); tick();
      d = $urandom(); s_ack = 1'b1; s_data = d; #1;
      checks++;
      if (m_ack !== (3'b001 << exp) || m_data[exp] !== d)
        begin errors++; $display("FAIL rr_ack%0d got m_ack=%b data=%h want master %0d data=%h", g, m_ack, m_data[exp], exp, d); end
      mdl_last = exp;
      tick();
      s_ack = 1'b0;
    end
    m_re = 3'b000;
  endtask

  task automatic test_fixed();
    logic [31:0] d;
    f_m_addr[1] = 32'hB100; f_m_addr[2] = 32'hB200; f_m_sel = '1;
    f_m_re = 3'b110;
    for (int r = 0; r < 3; r++) begin
      tick();
      checks++;
      if (f_s_re !== 1'b1 || f_s_addr !== 32'hB100)
        begin errors++; $display("FAIL fixed_grant%0d got s_re=%b s_addr=%h want 1/b100", r, f_s_re, f_s_addr); end
      tick(); tick();
      d = $urandom(); f_s_ack = 1'b1; f_s_data = d; #1;
      checks++;
      if (f_m_ack !== 3'b010 || f_m_data[1] !== d)
        begin errors++; $display("FAIL fixed_ack%0d got m_ack=%b want 010", r, f_m_ack); end
      tick();
      f_s_ack = 1'b0;
    end
    f_m_re = 3'b100;
    tick();
    checks++;
    if (f_s_re !== 1'b1 || f_s_addr !== 32'hB200)
      begin errors++; $display("FAIL fixed_low got s_re=%b s_addr=%h want 1/b200", f_s_re, f_s_addr); end
    tick(); tick();
    f_s_ack = 1'b1; #1;
    checks++;
    if (f_m_ack !== 3'b100) begin errors++; $display("FAIL fixed_low_ack got %b want 100", f_m_ack); end
    tick();
    f_s_ack = 1'b0; f_m_re = 3'b000;
    checks++;
    if (f_s_re !== 1'b0) begin errors++; $display("FAIL fixed_release got s_re=%b want 0", f_s_re); end
  endtask

  task automatic test_violation();
    m_re = 3'b001; m_addr[0] = 32'hC0C0_0000; m_sel[0] = 4'h3;
    tick();
    checks++;
    if (s_re !== 1'b1 || s_addr !== 32'hC0C0_0000) begin errors++; $display("FAIL viol_grant got s_addr=%h want c0c00000", s_addr); end
    m_re = 3'b000; m_addr[0] = 32'hFFFF_0000; m_sel[0] = 4'hC;
    tick();
    checks++;
    if (s_re !== 1'b1 || s_addr !== 32'hC0C0_0000 || s_sel !== 4'h3)
      begin errors++; $display("FAIL viol_hold got s_re=%b s_addr=%h s_sel=%h want 1/c0c00000/3", s_re, s_addr, s_sel); end
    s_ack = 1'b1; #1;
    checks++;
    if (m_ack !== 3'b001) begin errors++; $display("FAIL viol_ack got %b want 001", m_ack); end
    tick();
    mdl_last = 0;
    // cache acks while nothing is in flight
    #1;
    checks++;
    if (m_ack !== 3'b000) begin errors++; $display("FAIL spurious_ack got %b want 000", m_ack); end
    tick();
    s_ack = 1'b0;
    checks++;
    if (s_re !== 1'b0) begin errors++; $display("FAIL spurious_state got s_re=%b want 0", s_re); end
  endtask

  task automatic test_stress();
    logic [2:0]  req, prev_req, waiting, drop, exp_ack;
    logic [31:0] addr[3], prev_addr[3];
    logic [3:0]  sel[3], prev_sel[3];
    logic [31:0] exp_addr, dat, tmp;
    logic [3:0]  exp_sel;
    bit          prev_s_re, ack_prev, outstanding, ack_now, draining;
    int          owner, cnt, w;
    req = '0; waiting = '0; drop = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; sel[i] = '0; end
    prev_req = '0; prev_addr = addr; prev_sel = sel;
    prev_s_re = s_re; ack_prev = 1'b0; outstanding = 1'b0;
    owner = 0; cnt = 0; exp_addr = '0; exp_sel = '0;
    for (int cyc = 0; cyc < 1800; cyc++) begin
      draining = (cyc >= 1500);
      if (draining && waiting == 3'b000 && !outstanding) break;
      tick();
      if (!prev_s_re) begin
        if (prev_req != 3'b000) begin
          w = rr_pick(prev_req, mdl_last);
          checks++;
          if (s_re !== 1'b1 || s_addr !== prev_addr[w] || s_sel !== prev_sel[w])
            begin errors++; $display("FAIL stress_grant got s_re=%b s_addr=%h want master %0d addr=%h", s_re, s_addr, w, prev_addr[w]); end
          checks++;
          if (outstanding) begin errors++; $display("FAIL stress_double_grant got outstanding=1 want 0"); end
          outstanding = 1'b1; owner = w; exp_addr = prev_addr[w]; exp_sel = prev_sel[w];
          cnt = $urandom_range(5, 0);
        end else begin
          checks++;
          if (s_re !== 1'b0) begin errors++; $display("FAIL stress_idle got s_re=%b want 0", s_re); end
        end
      end else if (ack_prev) begin
        checks++;
        if (s_re !== 1'b0) begin errors++; $display("FAIL stress_release got s_re=%b want 0", s_re); end
      end else begin
        checks++;
        if (s_re !== 1'b1 || s_addr !== exp_addr || s_sel !== exp_sel)
          begin errors++; $display("FAIL stress_hold got s_re=%b s_addr=%h want 1/%h", s_re, s_addr, exp_addr); end
      end
      for (int i = 0; i < 3; i++) begin
        if (drop[i]) begin
          req[i] = 1'b0; drop[i] = 1'b0;
        end else if (!waiting[i] && !draining && $urandom_range(3, 0) == 0) begin
          tmp = $urandom();
          req[i] = 1'b1; waiting[i] = 1'b1;
          addr[i] = {tmp[31:2], 2'(i)};
          sel[i] = 4'($urandom_range(15, 1));
        end
      end
      if (outstanding && $urandom_range(7, 0) == 0) begin
        tmp = $urandom();
        addr[owner] = tmp;
      end
      if (outstanding && $urandom_range(15, 0) == 0) req[owner] = 1'b0;
      ack_now = 1'b0;
      if (outstanding) begin
        if (cnt == 0) ack_now = 1'b1;
        else cnt--;
      end
      s_ack = ack_now || (!outstanding && $urandom_range(7, 0) == 0);
      dat = $urandom(); s_data = dat;
      m_re = req;
      for (int i = 0; i < 3; i++) begin m_addr[i] = addr[i]; m_sel[i] = sel[i]; end
      #1;
      exp_ack = ack_now ? (3'b001 << owner) : 3'b000;
      checks++;
      if (m_ack !== exp_ack) begin errors++; $display("FAIL stress_ack got %b want %b", m_ack, exp_ack); end
      checks++;
      if ($countones(m_ack) > 1) begin errors++; $display("FAIL stress_onehot got %b want at most one bit", m_ack); end
      if (ack_now) begin
        checks++;
        if (m_data[0] !== dat || m_data[1] !== dat || m_data[2] !== dat)
          begin errors++; $display("FAIL stress_data got %h want %h", m_data[owner], dat); end
        outstanding = 1'b0; waiting[owner] = 1'b0; drop[owner] = 1'b1; mdl_last = owner;
      end
      prev_req = req; prev_addr = addr; prev_sel = sel;
      prev_s_re = s_re; ack_prev = ack_now;
    end
    checks++;
    if (waiting != 3'b000 || outstanding)
      begin errors++; $display("FAIL stress_drain got waiting=%b outstanding=%b want 000/0", waiting, outstanding); end
    m_re = 3'b000; s_ack = 1'b0;
  endtask

  initial begin
    m_re = '0; m_sel = '0; m_addr = '0; s_ack = 1'b0; s_data = '0;
    f_m_re = '0; f_m_sel = '0; f_m_addr = '0; f_s_ack = 1'b0; f_s_data = '0;
    test_reset();
    test_single();
    test_rr_fair();
    test_fixed();
    test_violation();
    test_stress();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
